fifo_txuart: RTL and testbench



---
 rtl/fifo_txuart_pkg.sv | 17 +
 rtl/fifo_txuart_baud_counter.sv | 45 ++++
 rtl/fifo_txuart.sv | 135 +++++++++++++
 tb/tb_fifo_txuart.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_txuart_pkg.sv
// Shared definitions for the FIFO-fed 8N1 UART transmitter: state encoding and frame constants.
package fifo_txuart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } tx_state_e;

  localparam int          BAUD_CNT_W  = 24;
  localparam logic [23:0] DEFAULT_CPB = 24'd868;
  localparam int          DATA_BITS   = 8;
  localparam int          FRAME_BITS  = 10;

endpackage

// File: rtl/fifo_txuart_baud_counter.sv
// Bit-period down counter: reloads on i_load and pulses o_tick once when it reaches zero.
module baud_counter
  import fifo_txuart_pkg::*;
#(
  parameter int CNT_W = BAUD_CNT_W
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_reload,
  output logic             o_tick
);

  localparam logic [CNT_W-1:0] ONE = 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             run_q, run_d;

  // run_q keeps the terminal count from ticking again while the FSM is idle or in break.
  always_comb begin
    cnt_d = cnt_q;
    run_d = run_q;
    if (i_load) begin
      cnt_d = i_reload;
      run_d = 1'b1;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - ONE;
    end else begin
      run_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

  assign o_tick = run_q && (cnt_q == '0);

endmodule

// File: rtl/fifo_txuart.sv
// 8N1 UART transmitter draining a byte FIFO: one pop per frame, back-to-back frames, line break.
module fifo_txuart
  import fifo_txuart_pkg::*;
#(
  parameter logic [23:0] CLOCKS_PER_BAUD = DEFAULT_CPB
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_empty_n,
  input  logic [7:0] i_data,
  output logic       o_rd,
  input  logic       i_break,
  output logic       o_uart_tx,
  output logic       o_busy
);

  localparam logic [2:0]  LAST_BIT = 3'(DATA_BITS - 1);
  localparam logic [23:0] RELOAD   = CLOCKS_PER_BAUD - 24'd1;

  tx_state_e  state_q, state_d;
  logic [7:0] shreg_q, shreg_d;
  logic [2:0] bitcnt_q, bitcnt_d;
  logic       rd_q, rd_d;
  logic       tx_q, tx_d;
  logic       busy_q, busy_d;
  logic       baud_load;
  logic       baud_tick;

  baud_counter #(
    .CNT_W(BAUD_CNT_W)
  ) u_baud (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_load  (baud_load),
    .i_reload(RELOAD),
    .o_tick  (baud_tick)
  );

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bitcnt_d  = bitcnt_q;
    rd_d      = 1'b0;
    baud_load = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_break) begin
          state_d = ST_BREAK;
        end else if (i_empty_n) begin
          shreg_d   = i_data;
          rd_d      = 1'b1;
          baud_load = 1'b1;
          state_d   = ST_START;
        end
      end
      ST_START: begin
        if (baud_tick) begin
          bitcnt_d  = 3'd0;
          baud_load = 1'b1;
          state_d   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (baud_tick) begin
          baud_load = 1'b1;
          shreg_d   = {1'b0, shreg_q[7:1]};
          if (bitcnt_q == LAST_BIT) begin
            bitcnt_d = 3'd0;
            state_d  = ST_STOP;
          end else begin
            bitcnt_d = bitcnt_q + 3'd1;
          end
        end
      end
      ST_STOP: begin
        if (baud_tick) begin
          if (!i_break && i_empty_n) begin
            shreg_d   = i_data;
            rd_d      = 1'b1;
            baud_load = 1'b1;
            state_d   = ST_START;
          end else if (i_break) begin
            state_d = ST_BREAK;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_BREAK: begin
        // Leaving break through STOP guarantees a full high bit before the next start.
        if (!i_break) begin
          baud_load = 1'b1;
          state_d   = ST_STOP;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Line and busy are registered from the current state, so they trail the pop by one cycle.
  always_comb begin
    case (state_q)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shreg_q[0];
      ST_BREAK: tx_d = 1'b0;
      default:  tx_d = 1'b1;
    endcase
    busy_d = (state_q != ST_IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      bitcnt_q <= 3'd0;
      rd_q     <= 1'b0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      rd_q     <= rd_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
    end
  end

  always_ff @(posedge i_clk) begin
    shreg_q <= shreg_d;
  end

  assign o_rd      = rd_q;
  assign o_uart_tx = tx_q;
  assign o_busy    = busy_q;

endmodule

// File: tb/tb_fifo_txuart.sv
// Directed and randomized bench for fifo_txuart with a byte-FIFO model and a line decoder.
module tb_fifo_txuart;

  localparam int CPB = 4;

  logic       clk;
  logic       rst;
  logic       empty_n;
  logic [7:0] data;
  logic       rd;
  logic       brk;
  logic       tx;
  logic       busy;

  fifo_txuart #(
    .CLOCKS_PER_BAUD(24'd4)
  ) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_empty_n(empty_n),
    .i_data   (data),
    .o_rd     (rd),
    .i_break  (brk),
    .o_uart_tx(tx),
    .o_busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  logic s_rd, s_tx, s_busy;
  logic [7:0] fifo_q[$];
  logic [7:0] popped[$];
  logic txlog[0:511];
  logic rdlog[0:511];
  logic busylog[0:511];
  int   rel;

  logic       dec_en;
  int         dec_st, dec_cnt;
  logic [7:0] dec_byte;
  int         stress_pops, stress_frames;

  task automatic chk_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_fifo();
    empty_n = (fifo_q.size() != 0);
    data    = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
  endtask

  task automatic push(input logic [7:0] b);
    fifo_q.push_back(b);
    drive_fifo();
  endtask

  task automatic decode();
    int k;
    case (dec_st)
      0: if (!s_tx) begin
        dec_st  = 1;
        dec_cnt = 0;
      end
      1: begin
        dec_cnt++;
        if (dec_cnt % CPB == CPB / 2) begin
          k = dec_cnt / CPB;
          if (k >= 1 && k <= 8) begin
            dec_byte[k-1] = s_tx;
          end else if (k == 9) begin
            if (s_tx) begin
              stress_frames++;
              chk_vec("stress_pop_before_frame", popped.size() != 0, 1'b1);
              if (popped.size() != 0) chk_vec("stress_byte", dec_byte, popped.pop_front());
              dec_st = 0;
            end else begin
              dec_st = 2;
            end
          end
        end
      end
      default: if (s_tx) dec_st = 0;
    endcase
  endtask

  // One clock: sample outputs away from the edge, then let the FIFO model react to a pop.
  task automatic cyc();
    @(posedge clk);
    #1;
    s_rd   = rd;
    s_tx   = tx;
    s_busy = busy;
    if (s_rd) begin
      chk_vec("pop_nonempty", fifo_q.size() != 0, 1'b1);
      if (fifo_q.size() != 0) popped.push_back(fifo_q.pop_front());
      if (dec_en) stress_pops++;
    end
    if (dec_en) decode();
    drive_fifo();
  endtask

  task automatic log_now();
    txlog[rel]   = s_tx;
    rdlog[rel]   = s_rd;
    busylog[rel] = s_busy;
  endtask

  task automatic wait_rd(input string tag, input int max, output int waited);
    waited = 0;
    for (int i = 0; i < max; i++) begin
      cyc();
      waited++;
      if (s_rd) break;
    end
    if (!s_rd) chk_vec(tag, 1'b0, 1'b1);
    rel = 0;
    log_now();
  endtask

  task automatic run_to(input int r);
    while (rel < r && rel < 511) begin
      cyc();
      rel++;
      log_now();
    end
  endtask

  function automatic logic [39:0] frame40(input int s);
    logic [39:0] v;
    for (int k = 0; k < 40; k++) v[k] = txlog[s+k];
    return v;
  endfunction

  function automatic int count_rd(input int a, input int b);
    int c = 0;
    for (int i = a; i <= b; i++) c += int'(rdlog[i]);
    return c;
  endfunction

  function automatic int count_low(input int a, input int b);
    int c = 0;
    for (int i = a; i <= b; i++) c += int'(!txlog[i]);
    return c;
  endfunction

  function automatic int count_busy(input int a, input int b);
    int c = 0;
    for (int i = a; i <= b; i++) c += int'(busylog[i]);
    return c;
  endfunction

  initial begin
    int w;
    int idle_rd, idle_low, brk_left;
    rst = 1'b1; brk = 1'b0; empty_n = 1'b0; data = 8'h00;
    dec_en = 1'b0; dec_st = 0; dec_cnt = 0; dec_byte = 8'h00;
    stress_pops = 0; stress_frames = 0; rel = 0;
    repeat (3) cyc();
    chk_vec("rst_tx", s_tx, 1'b1);
    chk_vec("rst_rd", s_rd, 1'b0);
    chk_vec("rst_busy", s_busy, 1'b0);
    rst = 1'b0;
    cyc();

    // Single byte 0x55
    push(8'h55);
    wait_rd("rd55_timeout", 10, w);
    chk_vec("rd55_latency", w, 1);
    chk_vec("rd55_tx_at_pop", txlog[0], 1'b1);
    chk_vec("rd55_busy_at_pop", busylog[0], 1'b0);
    run_to(41);
    chk_vec("frame55", frame40(1), 40'hF0F0F0F0F0);
    chk_vec("busy55_len", count_busy(1, 40), 40);
    chk_vec("busy55_fall", busylog[41], 1'b0);
    chk_vec("rd55_single", count_rd(1, 41), 0);

    // Three preloaded bytes, back to back
    push(8'h00); push(8'hFF); push(8'hA5);
    wait_rd("rd3_timeout", 10, w);
    run_to(121);
    chk_vec("rd3_at40", rdlog[40], 1'b1);
    chk_vec("rd3_at80", rdlog[80], 1'b1);
    chk_vec("rd3_count", count_rd(1, 121), 2);
    chk_vec("frame00", frame40(1), 40'hF000000000);
    chk_vec("frameFF", frame40(41), 40'hFFFFFFFFF0);
    chk_vec("frameA5", frame40(81), 40'hFF0F00F0F0);
    chk_vec("busy3_rise", busylog[1], 1'b1);
    chk_vec("busy3_last", busylog[120], 1'b1);
    chk_vec("busy3_fall", busylog[121], 1'b0);
    chk_vec("fifo3_empty", fifo_q.size(), 0);

    // Break raised during bit 3 of 0x3C, next byte queued during the break
    push(8'h3C);
    wait_rd("rd3c_timeout", 10, w);
    run_to(17);
    brk = 1'b1;
    run_to(20);
    push(8'h81);
    run_to(60);
    brk = 1'b0;
    run_to(106);
    chk_vec("frame3C", frame40(1), 40'hF00FFFF000);
    chk_vec("brk_no_pop", count_rd(1, 64), 0);
    chk_vec("brk_low", count_low(41, 61), 21);
    chk_vec("brk_busy", busylog[50], 1'b1);
    chk_vec("brk_stop_high", count_low(62, 65), 0);
    chk_vec("brk_next_rd", rdlog[65], 1'b1);
    chk_vec("frame81", frame40(66), 40'hFF000000F0);
    chk_vec("brk_busy_fall", busylog[106], 1'b0);

    // Reset in the middle of a frame with a second byte still queued
    push(8'h12); push(8'h34);
    wait_rd("rd12_timeout", 10, w);
    run_to(29);
    rst = 1'b1;
    run_to(30);
    rst = 1'b0;
    run_to(72);
    chk_vec("mrst_tx_before", txlog[29], 1'b0);
    chk_vec("mrst_tx", txlog[30], 1'b1);
    chk_vec("mrst_busy", busylog[30], 1'b0);
    chk_vec("mrst_no_pop", count_rd(1, 30), 0);
    chk_vec("mrst_restart_rd", rdlog[31], 1'b1);
    chk_vec("frame34", frame40(32), 40'hF00FF0F000);
    chk_vec("mrst_busy_fall", busylog[72], 1'b0);

    // Long idle with an empty FIFO, then 0x80
    idle_rd = 0; idle_low = 0;
    repeat (1000) begin
      cyc();
      idle_rd  += int'(s_rd);
      idle_low += int'(!s_tx);
    end
    chk_vec("idle_rd", idle_rd, 0);
    chk_vec("idle_low", idle_low, 0);
    push(8'h80);
    wait_rd("rd80_timeout", 10, w);
    chk_vec("rd80_latency", w, 1);
    run_to(41);
    chk_vec("rd80_tx_at_pop", txlog[0], 1'b1);
    chk_vec("frame80", frame40(1), 40'hFF00000000);

    // Random FIFO traffic and break requests, decoded from the line
    popped.delete();
    dec_en = 1'b1; dec_st = 0;
    brk_left = 0;
    for (int i = 0; i < 4000; i++) begin
      cyc();
      if (brk_left > 0) begin
        brk_left--;
        if (brk_left == 0) brk = 1'b0;
      end else if ($urandom % 400 == 0) begin
        brk = 1'b1;
        brk_left = 100 + int'($urandom % 40);
      end
      if (fifo_q.size() < 4 && $urandom % 30 == 0) push(8'($urandom));
    end
    brk = 1'b0;
    w = 0;
    for (int i = 0; i < 2000; i++) begin
      cyc();
      if (fifo_q.size() == 0 && !s_busy && dec_st == 0) begin
        w = 1;
        break;
      end
    end
    chk_vec("stress_drain", w, 1);
    chk_vec("stress_pop_vs_frame", stress_frames, stress_pops);
    chk_vec("stress_undelivered", popped.size(), 0);
    chk_vec("stress_activity", stress_pops > 20, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
